// File: rtl/mem_access_adapter.sv
// Sub-word load/store adapter between a CPU data port and a word-wide bus (RMW or byte-strobe writes).
// Optional saturating access counters are compiled in with MEM_ADAPTER_STATS_EN.
module mem_access_lane (
  input  logic       sel,
  input  logic       keep,
  input  logic [7:0] wbyte,
  input  logic [7:0] rbyte,
  output logic [7:0] mbyte
);
  assign mbyte = sel ? wbyte : (keep ? rbyte : 8'h00);
endmodule

module mem_access_adapter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter bit BIG_ENDIAN  = 1,
  parameter bit USE_BYTE_EN = 0
) (
  input  logic                clk,
  input  logic                res,
  input  logic                up_valid,
  output logic                up_ready,
  input  logic                up_write,
  input  logic [1:0]          up_len,
  input  logic                up_signed,
  input  logic [ADDR_W-1:0]   up_addr,
  input  logic [DATA_W-1:0]   up_wdata,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                bus_req,
  output logic                bus_write,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic [DATA_W-1:0]   bus_rdata,
`ifdef MEM_ADAPTER_STATS_EN
  output logic [15:0]         stat_acc,
  output logic [15:0]         stat_rmw,
  output logic [15:0]         stat_err,
`endif
  input  logic                bus_ready
);
  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, READ, WRITE, RMW_RD, RMW_WR, ERR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          len_q;
  logic                write_q, signed_q;
  logic [DATA_W-1:0]   wdata_q, mrg_q, merged, field, ld;
  logic [NB-1:0]       sel;
  logic [NB-1:0][7:0]  wrep;
  logic                keep, done, misal, full;
  logic [3:0]          szm;
  int                  size, base;

  // Request classification at accept time
  always_comb begin
    szm   = (4'd1 << up_len) - 4'd1;
    misal = (|(up_addr[2:0] & szm[2:0])) || (up_len == 2'd3 && DATA_W == 32);
    full  = ((4'd1 << up_len) == 4'(NB));
  end

  // Lane selection from the latched request; clamps keep illegal lengths in range
  always_comb begin
    size = 1 << len_q;
    if (size > NB) size = NB;
    base = BIG_ENDIAN ? (NB - int'(addr_q[OFFW-1:0]) - size) : int'(addr_q[OFFW-1:0]);
    if (base < 0) base = 0;
    for (int i = 0; i < NB; i++) begin
      sel[i]  = (i >= base) && (i < base + size);
      wrep[i] = wdata_q[8*(i % size) +: 8];
    end
    field = bus_rdata >> (8 * base);
    ld    = field;
    for (int i = 0; i < DATA_W; i++)
      if (i >= 8 * size) ld[i] = signed_q & field[8*size-1];
  end

  assign keep = (state_q == RMW_RD);

  for (genvar g = 0; g < NB; g++) begin : g_lane
    mem_access_lane u_lane (
      .sel   (sel[g]),
      .keep  (keep),
      .wbyte (wrep[g]),
      .rbyte (bus_rdata[8*g +: 8]),
      .mbyte (merged[8*g +: 8])
    );
  end

  always_comb begin
    state_d   = state_q;
    up_ready  = 1'b0;
    bus_req   = 1'b0;
    bus_write = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_be    = '0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        up_ready = 1'b1;
        if (up_valid) begin
          if (misal)                          state_d = ERR;
          else if (!up_write)                 state_d = READ;
          else if (full || USE_BYTE_EN)       state_d = WRITE;
          else                                state_d = RMW_RD;
        end
      end
      READ, RMW_RD: begin
        bus_req  = 1'b1;
        bus_addr = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        bus_be   = '1;
        if (bus_ready) begin
          state_d = (state_q == READ) ? IDLE : RMW_WR;
          done    = (state_q == READ);
        end
      end
      WRITE, RMW_WR: begin
        bus_req   = 1'b1;
        bus_write = 1'b1;
        bus_addr  = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        bus_wdata = (state_q == WRITE) ? merged : mrg_q;
        bus_be    = (state_q == WRITE && USE_BYTE_EN) ? sel : '1;
        if (bus_ready) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      ERR: begin
        state_d = IDLE;
        done    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      write_q   <= 1'b0;
      signed_q  <= 1'b0;
      wdata_q   <= '0;
      mrg_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && up_valid) begin
        addr_q   <= up_addr;
        len_q    <= up_len;
        write_q  <= up_write;
        signed_q <= up_signed;
        wdata_q  <= up_wdata;
      end
      if (state_q == RMW_RD && bus_ready) mrg_q <= merged;
      rsp_valid <= done;
      rsp_err   <= done && (state_q == ERR);
      rsp_rdata <= (done && state_q == READ && !write_q) ? ld : '0;
    end
  end

`ifdef MEM_ADAPTER_STATS_EN
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      stat_acc <= '0;
      stat_rmw <= '0;
      stat_err <= '0;
    end else begin
      if (done && state_q != ERR && stat_acc != 16'hFFFF) stat_acc <= stat_acc + 16'd1;
      if (done && state_q == RMW_WR && stat_rmw != 16'hFFFF) stat_rmw <= stat_rmw + 16'd1;
      if (done && state_q == ERR && stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_access_adapter.sv
// Directed bench for mem_access_adapter: RMW big-endian, byte-enable little-endian and 64-bit instances.
module tb_mem_access_adapter;
  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [2:0]  vld;
  logic        wr, sgn, brdy;
  logic [1:0]  len;
  logic [31:0] addr;
  logic [63:0] wd, brd;

  logic        a_rdy, a_rv, a_re, a_breq, a_bwr;
  logic [31:0] a_rd, a_baddr, a_bwd;
  logic [3:0]  a_be;
  logic        b_rdy, b_rv, b_re, b_breq, b_bwr;
  logic [31:0] b_rd, b_baddr, b_bwd;
  logic [3:0]  b_be;
  logic        c_rdy, c_rv, c_re, c_breq, c_bwr;
  logic [63:0] c_rd, c_bwd;
  logic [31:0] c_baddr;
  logic [7:0]  c_be;
`ifdef MEM_ADAPTER_STATS_EN
  logic [15:0] a_sacc, a_srmw, a_serr, b_sacc, b_srmw, b_serr, c_sacc, c_srmw, c_serr;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_adapter #(.DATA_W(32), .BIG_ENDIAN(1), .USE_BYTE_EN(0)) u_a (
    .clk(clk), .res(res), .up_valid(vld[0]), .up_ready(a_rdy), .up_write(wr), .up_len(len),
    .up_signed(sgn), .up_addr(addr), .up_wdata(wd[31:0]), .rsp_valid(a_rv), .rsp_err(a_re),
    .rsp_rdata(a_rd), .bus_req(a_breq), .bus_write(a_bwr), .bus_addr(a_baddr), .bus_wdata(a_bwd),
    .bus_be(a_be), .bus_rdata(brd[31:0]),
`ifdef MEM_ADAPTER_STATS_EN
    .stat_acc(a_sacc), .stat_rmw(a_srmw), .stat_err(a_serr),
`endif
    .bus_ready(brdy));

  mem_access_adapter #(.DATA_W(32), .BIG_ENDIAN(0), .USE_BYTE_EN(1)) u_b (
    .clk(clk), .res(res), .up_valid(vld[1]), .up_ready(b_rdy), .up_write(wr), .up_len(len),
    .up_signed(sgn), .up_addr(addr), .up_wdata(wd[31:0]), .rsp_valid(b_rv), .rsp_err(b_re),
    .rsp_rdata(b_rd), .bus_req(b_breq), .bus_write(b_bwr), .bus_addr(b_baddr), .bus_wdata(b_bwd),
    .bus_be(b_be), .bus_rdata(brd[31:0]),
`ifdef MEM_ADAPTER_STATS_EN
    .stat_acc(b_sacc), .stat_rmw(b_srmw), .stat_err(b_serr),
`endif
    .bus_ready(brdy));

  mem_access_adapter #(.DATA_W(64), .BIG_ENDIAN(1), .USE_BYTE_EN(0)) u_c (
    .clk(clk), .res(res), .up_valid(vld[2]), .up_ready(c_rdy), .up_write(wr), .up_len(len),
    .up_signed(sgn), .up_addr(addr), .up_wdata(wd), .rsp_valid(c_rv), .rsp_err(c_re),
    .rsp_rdata(c_rd), .bus_req(c_breq), .bus_write(c_bwr), .bus_addr(c_baddr), .bus_wdata(c_bwd),
    .bus_be(c_be), .bus_rdata(brd),
`ifdef MEM_ADAPTER_STATS_EN
    .stat_acc(c_sacc), .stat_rmw(c_srmw), .stat_err(c_serr),
`endif
    .bus_ready(brdy));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] which, input logic w, input logic [1:0] l,
                     input logic s, input logic [31:0] a, input logic [63:0] d);
    vld = which; wr = w; len = l; sgn = s; addr = a; wd = d;
  endtask

  initial begin
    vld = '0; wr = 0; sgn = 0; len = 0; addr = 0; wd = 0; brd = 0; brdy = 0;
    #3;
    chk("rst_up_ready", 64'(a_rdy), 64'd1);
    chk("rst_bus_req", 64'(a_breq), 64'd0);
    chk("rst_rsp_valid", 64'(a_rv), 64'd0);
    chk("rst_bus_be", 64'(a_be), 64'd0);
    chk("rst_bus_addr", 64'(a_baddr), 64'd0);
    chk("rst_rsp_rdata", 64'(a_rd), 64'd0);
    @(negedge clk); res = 1'b1;
    step;

    // RMW byte store, big-endian
    req(3'b001, 1, 2'd0, 0, 32'h1001, 64'hAB); brd = 64'h11223344; brdy = 1;
    step; vld = '0;
    chk("rmw_rd_req", 64'(a_breq), 64'd1);
    chk("rmw_rd_write", 64'(a_bwr), 64'd0);
    chk("rmw_rd_addr", 64'(a_baddr), 64'h1000);
    chk("rmw_rd_be", 64'(a_be), 64'hF);
    chk("rmw_busy_ready", 64'(a_rdy), 64'd0);
    step;
    chk("rmw_wr_write", 64'(a_bwr), 64'd1);
    chk("rmw_wr_wdata", 64'(a_bwd), 64'h11AB3344);
    chk("rmw_wr_be", 64'(a_be), 64'hF);
    chk("rmw_no_early_rsp", 64'(a_rv), 64'd0);
    step;
    chk("rmw_rsp_valid", 64'(a_rv), 64'd1);
    chk("rmw_rsp_err", 64'(a_re), 64'd0);
    chk("rmw_rsp_rdata", 64'(a_rd), 64'd0);
    chk("rmw_ready_again", 64'(a_rdy), 64'd1);

    // Back-to-back signed halfword load presented in the rsp cycle
    req(3'b001, 0, 2'd1, 1, 32'h2002, 0); brd = 64'h1234F00D;
    step; vld = '0;
    chk("b2b_accepted", 64'(a_breq), 64'd1);
    chk("ld_addr", 64'(a_baddr), 64'h2000);
    chk("ld_rsp_cleared", 64'(a_rv), 64'd0);
    step;
    chk("ldh_s_valid", 64'(a_rv), 64'd1);
    chk("ldh_s_rdata", 64'(a_rd), 64'hFFFFF00D);
    req(3'b001, 0, 2'd1, 0, 32'h2002, 0);
    step; vld = '0; step;
    chk("ldh_u_rdata", 64'(a_rd), 64'h0000F00D);

    // Misaligned halfword
    req(3'b001, 0, 2'd1, 0, 32'h2001, 0);
    step; vld = '0;
    chk("err_no_bus", 64'(a_breq), 64'd0);
    step;
    chk("err_valid", 64'(a_rv), 64'd1);
    chk("err_flag", 64'(a_re), 64'd1);
    chk("err_rdata", 64'(a_rd), 64'd0);

    // Byte-enable halfword store, little-endian
    req(3'b010, 1, 2'd1, 0, 32'h3002, 64'hBEEF);
    step; vld = '0;
    chk("be_write_now", 64'(b_bwr), 64'd1);
    chk("be_mask", 64'(b_be), 64'hC);
    chk("be_wdata", 64'(b_bwd), 64'hBEEF0000);
    chk("be_addr", 64'(b_baddr), 64'h3000);
    step;
    chk("be_rsp", 64'(b_rv), 64'd1);
    req(3'b010, 0, 2'd0, 1, 32'h3003, 0); brd = 64'h80112233;
    step; vld = '0; step;
    chk("le_ldb_s", 64'(b_rd), 64'hFFFFFF80);

    // 64-bit instance
    req(3'b100, 0, 2'd2, 0, 32'h4006, 0);
    step; vld = '0;
    chk("d64_err_no_bus", 64'(c_breq), 64'd0);
    step;
    chk("d64_err_flag", 64'(c_re), 64'd1);
    chk("d64_err_rdata", c_rd, 64'd0);
    chk("d64_err_no_bus2", 64'(c_breq), 64'd0);
    req(3'b100, 0, 2'd3, 1, 32'h4008, 0); brd = 64'h8123456789ABCDEF;
    step; vld = '0;
    chk("d64_dw_addr", 64'(c_baddr), 64'h4008);
    step;
    chk("d64_dw_rdata", c_rd, 64'h8123456789ABCDEF);
    req(3'b100, 0, 2'd2, 0, 32'h4004, 0); brd = 64'h111111118BADF00D;
    step; vld = '0;
    chk("d64_w_addr", 64'(c_baddr), 64'h4000);
    step;
    chk("d64_w_rdata", c_rd, 64'h000000008BADF00D);
`ifdef MEM_ADAPTER_STATS_EN
    chk("stat_c_acc", 64'(c_sacc), 64'd2);
    chk("stat_c_err", 64'(c_serr), 64'd1);
    chk("stat_c_rmw", 64'(c_srmw), 64'd0);
    chk("stat_a_acc", 64'(a_sacc), 64'd3);
    chk("stat_a_rmw", 64'(a_srmw), 64'd1);
    chk("stat_a_err", 64'(a_serr), 64'd1);
`endif

    // Stalled RMW read, then asynchronous reset
    brdy = 0; brd = 64'h11223344;
    req(3'b001, 1, 2'd0, 0, 32'h1001, 64'hAB);
    step; vld = '0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", 64'(a_breq), 64'd1);
      chk("stall_addr", 64'(a_baddr), 64'h1000);
      step;
    end
    res = 1'b0; #1;
    chk("arst_req", 64'(a_breq), 64'd0);
    chk("arst_ready", 64'(a_rdy), 64'd1);
    chk("arst_rsp", 64'(a_rv), 64'd0);
    brdy = 1; #1; res = 1'b1;
    step;
    chk("post_rst_rsp", 64'(a_rv), 64'd0);
    chk("post_rst_req", 64'(a_breq), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
